// File: rtl/axis_byte_packer_pkg.sv
// Shared constants and helpers for the byte packer.
package axis_byte_packer_pkg;

  localparam int unsigned BYTE_W   = 8;
  // Widest keep vector the helper can produce; callers truncate to their own width.
  localparam int unsigned KEEP_MAX = 64;

  // One-hot keep bit for byte index idx.
  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned idx);
    logic [KEEP_MAX-1:0] one;
    one       = '0;
    one[0]    = 1'b1;
    keep_mask = one << idx;
  endfunction

endpackage

// File: rtl/axis_byte_packer.sv
// Packs a byte-wide AXI-Stream into 2*n-byte words, little-endian, with
// early close on in_tlast producing a short word with a byte-valid mask.
module axis_byte_packer
  import axis_byte_packer_pkg::*;
#(
  parameter int n  = 5,
  parameter int nb = n * 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      in_tdata,
  input  logic            in_tvalid,
  output logic            in_tready,
  input  logic            in_tlast,
  output logic [nb*2-1:0] out_tdata,
  output logic            out_tvalid,
  input  logic            out_tready,
  output logic [2*n-1:0]  out_tkeep,
  output logic            out_tlast
);

  localparam int KEEP_W = 2 * n;
  localparam int DATA_W = nb * 2;
  localparam int IDX_W  = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEEP_W - 1);

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] asm_data;
  logic [KEEP_W-1:0] asm_keep;

  logic [DATA_W-1:0] asm_merged;
  logic [KEEP_W-1:0] keep_merged;
  logic [KEEP_W-1:0] cur_mask;
  logic              accept;
  logic              word_done;

  // Ready only when the output slot is empty or is being drained this cycle.
  assign in_tready = ~reset & (~out_tvalid | out_tready);
  assign accept    = in_tvalid & in_tready;
  assign word_done = (idx == LAST_IDX) | in_tlast;
  assign cur_mask  = KEEP_W'(keep_mask(32'(idx)));

  // Merge the incoming byte into the assembly word at the current index.
  always_comb begin
    asm_merged  = asm_data;
    keep_merged = asm_keep | cur_mask;
    for (int unsigned k = 0; k < KEEP_W; k++) begin
      if (idx == IDX_W'(k)) begin
        asm_merged[k*BYTE_W +: BYTE_W] = in_tdata;
      end
    end
  end

  // Index counter, assembly register and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      asm_data   <= '0;
      asm_keep   <= '0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tlast  <= 1'b0;
      out_tvalid <= 1'b0;
    end else begin
      if (out_tvalid && out_tready) begin
        out_tvalid <= 1'b0;
      end
      if (accept) begin
        if (word_done) begin
          // A completing word overrides the drain above, keeping out_tvalid high.
          out_tdata  <= asm_merged;
          out_tkeep  <= keep_merged;
          out_tlast  <= in_tlast;
          out_tvalid <= 1'b1;
          asm_data   <= '0;
          asm_keep   <= '0;
          idx        <= '0;
        end else begin
          asm_data   <= asm_merged;
          asm_keep   <= keep_merged;
          idx        <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed and randomized-gap checks of the byte packer with n=2 (4-byte words).
module tb_axis_byte_packer;

  localparam int N  = 2;
  localparam int NB = N * 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      in_tdata;
  logic            in_tvalid;
  logic            in_tready;
  logic            in_tlast;
  logic [NB*2-1:0] out_tdata;
  logic            out_tvalid;
  logic            out_tready;
  logic [2*N-1:0]  out_tkeep;
  logic            out_tlast;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [8:0]  exp_q[$];   // {last, byte}
  bit          prod_done;
  int unsigned last_cnt;

  axis_byte_packer #(.n(N), .nb(NB)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_tdata  (in_tdata),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .in_tlast  (in_tlast),
    .out_tdata (out_tdata),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tkeep (out_tkeep),
    .out_tlast (out_tlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until accepted; returns at #1 after the accepting edge.
  task automatic push(input logic [7:0] d, input logic last);
    logic        r;
    int unsigned guard;
    in_tdata  = d;
    in_tlast  = last;
    in_tvalid = 1'b1;
    guard     = 0;
    do begin
      @(negedge clk);
      r = in_tready;
      @(posedge clk);
      #1;
      guard++;
    end while (!r && guard < 2000);
    if (!r) check("push_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [7:0]  b;
    logic [3:0]  k;
    logic [8:0]  e;
    int unsigned cyc;

    reset      = 1'b1;
    in_tdata   = '0;
    in_tvalid  = 1'b0;
    in_tlast   = 1'b0;
    out_tready = 1'b1;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_tvalid", 64'(out_tvalid), 64'd0);
      check("rst_tkeep",  64'(out_tkeep),  64'd0);
      check("rst_tdata",  64'(out_tdata),  64'd0);
      check("rst_tready", 64'(in_tready),  64'd0);
    end
    reset = 1'b0;
    #1;
    check("post_rst_tready", 64'(in_tready), 64'd1);

    // Full word closed by in_tlast on the 4th byte.
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'h44, 1'b1);
    check("full_tvalid", 64'(out_tvalid), 64'd1);
    check("full_tdata",  64'(out_tdata),  64'h44332211);
    check("full_tkeep",  64'(out_tkeep),  64'hf);
    check("full_tlast",  64'(out_tlast),  64'd1);

    // Short packet immediately behind it; first byte accepted while word drains.
    push(8'hAA, 1'b0);
    check("full_one_cycle", 64'(out_tvalid), 64'd0);
    push(8'hBB, 1'b0);
    push(8'hCC, 1'b1);
    check("short_tvalid", 64'(out_tvalid), 64'd1);
    check("short_tdata",  64'(out_tdata),  64'h00CCBBAA);
    check("short_tkeep",  64'(out_tkeep),  64'h7);
    check("short_tlast",  64'(out_tlast),  64'd1);
    in_tvalid = 1'b0;
    @(posedge clk);
    #1;
    check("short_drained", 64'(out_tvalid), 64'd0);

    // Backpressure: first word stalls for five cycles.
    out_tready = 1'b0;
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    push(8'h04, 1'b0);
    in_tdata  = 8'h05;
    in_tlast  = 1'b0;
    in_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_tready", 64'(in_tready),  64'd0);
      check("stall_tvalid", 64'(out_tvalid), 64'd1);
      check("stall_tdata",  64'(out_tdata),  64'h04030201);
      check("stall_tkeep",  64'(out_tkeep),  64'hf);
      check("stall_tlast",  64'(out_tlast),  64'd0);
      @(posedge clk);
      #1;
    end
    out_tready = 1'b1;
    push(8'h05, 1'b0);
    check("stall_drained", 64'(out_tvalid), 64'd0);
    push(8'h06, 1'b0);
    push(8'h07, 1'b0);
    push(8'h08, 1'b1);
    check("second_tdata", 64'(out_tdata), 64'h08070605);
    check("second_tkeep", 64'(out_tkeep), 64'hf);
    check("second_tlast", 64'(out_tlast), 64'd1);
    in_tvalid = 1'b0;
    @(posedge clk);
    #1;

    // Random gaps on both sides, 200 packets of length 1..9.
    prod_done = 1'b0;
    last_cnt  = 0;
    fork
      begin
        for (int p = 0; p < 200; p++) begin
          int unsigned len;
          len = $urandom_range(9, 1);
          for (int unsigned j = 0; j < len; j++) begin
            if ($urandom_range(1, 0) == 1) begin
              in_tvalid = 1'b0;
              @(posedge clk);
              #1;
            end
            b = 8'($urandom_range(255, 0));
            exp_q.push_back({(j == len - 1), b});
            push(b, (j == len - 1));
          end
        end
        in_tvalid = 1'b0;
        prod_done = 1'b1;
      end
      begin
        cyc = 0;
        while (!(prod_done && exp_q.size() == 0 && !out_tvalid) && cyc < 20000) begin
          @(posedge clk);
          #1;
          out_tready = ($urandom_range(1, 0) == 1);
          @(negedge clk);
          cyc++;
          if (out_tvalid && out_tready) begin
            k = out_tkeep;
            check("rand_keep_shape", 64'(((k + 4'd1) & k) == 4'd0 && k != 4'd0), 64'd1);
            for (int unsigned m = 0; m < 4; m++) begin
              if (k[m]) begin
                if (exp_q.size() == 0) begin
                  check("rand_extra_byte", 64'd1, 64'd0);
                end else begin
                  e = exp_q.pop_front();
                  check("rand_byte", 64'(out_tdata[m*8 +: 8]), 64'(e[7:0]));
                  if (m == 3 || !k[m+1]) check("rand_last", 64'(out_tlast), 64'(e[8]));
                end
              end else begin
                check("rand_pad_zero", 64'(out_tdata[m*8 +: 8]), 64'd0);
              end
            end
            if (out_tlast) last_cnt++;
          end
        end
        if (cyc >= 20000) check("rand_timeout", 64'd0, 64'd1);
      end
    join
    check("rand_pkts", 64'(last_cnt), 64'd200);
    check("rand_leftover", 64'(exp_q.size()), 64'd0);
    out_tready = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a word discards the partial bytes.
    push(8'hEE, 1'b0);
    push(8'hFF, 1'b0);
    in_tvalid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tready", 64'(in_tready),  64'd0);
    check("midrst_tvalid", 64'(out_tvalid), 64'd0);
    reset = 1'b0;
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    check("midrst_no_word", 64'(out_tvalid), 64'd0);
    push(8'h04, 1'b1);
    check("midrst_tvalid2", 64'(out_tvalid), 64'd1);
    check("midrst_tdata",   64'(out_tdata),  64'h04030201);
    check("midrst_tkeep",   64'(out_tkeep),  64'hf);
    check("midrst_tlast",   64'(out_tlast),  64'd1);
    in_tvalid = 1'b0;
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_byte_packer.md
Name: axis_byte_packer

Overview:
- Upstream feeder for the n-byte processing stage: accepts a byte-wide AXI-Stream and packs 2*n consecutive bytes into one 2*nb-bit word.
- Output is registered and drives the downstream stage's in_tdata/in_tvalid/in_tready.
- in_tlast closes a short word early; the short word carries a byte-valid mask and a last flag.

Parameters:
- n, 5, number of bytes in the downstream output word; this block packs 2*n bytes per word.
- nb, n*8, number of bits in the downstream output word; this block's output is nb*2 bits.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active high
- in_tdata  input  8  input byte
- in_tvalid  input  1  1 = input byte valid
- in_tready  output  1  1 = block accepts the byte
- in_tlast  input  1  1 = last byte of a packet
- out_tdata  output  nb*2  packed word; byte k occupies bits [8k+7:8k]
- out_tvalid  output  1  1 = out_tdata valid
- out_tready  input  1  1 = downstream accepts the word
- out_tkeep  output  2*n  bit k = 1 when byte k is valid
- out_tlast  output  1  1 = word ends a packet

Behaviour:
- Interface (decided): one clock, clk; reset is synchronous and active high, sampled on the rising edge of clk.
- Reset values: out_tvalid=0, out_tdata=0, out_tkeep=0, out_tlast=0, byte index=0, assembly register=0.
- in_tready=0 while reset=1.
- Transfers: an input transfer occurs when in_tvalid & in_tready at a rising edge; an output transfer when out_tvalid & out_tready.
- in_tready = ~reset & (~out_tvalid | out_tready). This is combinational from out_tready. No combinational path from in_tvalid to out_*.
- Byte ordering: the first byte of a word goes to byte 0 (LSBs), little-endian. The index counts 0..2n-1.
- On each accepted byte: write the byte at the current index and set the keep bit for that index.
- Word completes when the index equals 2n-1, or when in_tlast=1.
- On completion (same edge):
  - the assembled word, with the incoming byte merged, loads into the output register;
  - out_tvalid=1, out_tlast=in_tlast, out_tkeep = accumulated mask;
  - the assembly register and mask clear to 0 and the index returns to 0.
- Latency: out_tvalid rises the cycle after the final byte is accepted.
- Throughput: sustains 1 byte per clk while out_tready=1.
- Output stability: while out_tvalid=1 and out_tready=0, out_tdata, out_tkeep and out_tlast hold stable and in_tready=0.
- out_tvalid drops after an output transfer unless a new word completes on the same edge. If one does, the output register reloads and out_tvalid stays 1.
- Partial words: unfilled bytes read as 0 and their keep bits are 0.
- in_tlast on the 2n-th byte gives a full word with all keep bits set and out_tlast=1.
- A one-byte packet gives out_tkeep=...0001, out_tlast=1.
- Bytes are never dropped or reordered. No idle-timeout flush; a word waits indefinitely for its closing byte or in_tlast.
- Reset mid-packet: the partial word and any pending output are discarded. The first byte after reset starts at index 0.
- Widths: the index is $clog2(2*n) bits. Comparison with 2n-1 must be exact for non-power-of-two 2n (default 10).

Decomposition:
- Package axis_byte_packer_pkg holds:
  - localparam BYTE_W = 8;
  - function keep_mask(idx), returning the one-hot keep bit for index idx.
- No sub-module. Single module containing the index counter, assembly register and output register.

Test Plan (n=2: 4-byte words, 32-bit out_tdata):
- Reset held for 3 cycles -> out_tvalid=0, out_tkeep=0, in_tready=0 throughout. in_tready=1 in the first cycle after reset is released.
- Bytes 11,22,33,44 on consecutive cycles, in_tlast on 44, out_tready=1 -> next cycle out_tdata=0x44332211, out_tkeep=4'b1111, out_tlast=1. Word lasts 1 cycle; no bubble on the following stream.
- Bytes AA,BB,CC with in_tlast on CC -> out_tdata=0x00CCBBAA, out_tkeep=4'b0111, out_tlast=1. The next packet starts at byte 0.
- 8-byte stream with out_tready=0 when the first word appears -> in_tready=0 and out_* stable for 5 stalled cycles. After out_tready=1, the second word follows with no lost or duplicated bytes.
- Random in_tvalid and out_tready gaps (50%) over 200 packets of length 1..9 -> scoreboard reconstruction of bytes from out_tkeep matches the input exactly. out_tlast count equals the packet count.
- reset pulsed after 2 bytes of a word -> no word is emitted for those bytes. The next bytes 01,02,03,04 produce 0x04030201.
